// File: rtl/rlc_pkg.sv
// Shared types and defaults for the run-length collector.
package rlc_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;
    // Record is {sat, len}; width follows the counter width.
    localparam int REC_W_DEF = CNT_W_DEF + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } rlc_state_e;

    // Record layout at the default counter width.
    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] len;
    } rlc_rec_t;

endpackage

// File: rtl/rlc_fifo.sv
// Generic synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. The head reads as zero
// while empty, so stale entries never appear on the output.
module rlc_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];
    assign level_o = cnt_q;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/run_len_collector.sv
// Run-length collector: counts sequencer step pulses per run, closes a
// {sat, len} record on each last pulse and queues it for a valid/ready sink.
// Optional macro RLC_STATS_EN adds wrapping accepted/dropped record counters.
module run_len_collector
    import rlc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_i,
    input  logic                   last_i,
    output logic [CNT_W-1:0]       len_o,
    output logic                   sat_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   drop_o,
`ifdef RLC_STATS_EN
    output logic [15:0]            runs_o,
    output logic [15:0]            drops_o,
`endif
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int REC_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rlc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, inc_cnt;
    logic             sat_q, sat_d, inc_sat;
    logic             push, pop, full, empty, drop_q;
    logic [REC_W-1:0] rec, head;

    // Saturating increment used by both continuing and closing steps.
    assign inc_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign inc_sat = sat_q | (cnt_q == CNT_MAX);

    // FSM state, counter and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Next state and record push; a coincident step counts into the closing record.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        push    = 1'b0;
        rec     = '0;
        case (state_q)
            IDLE: begin
                if (last_i) begin
                    push = 1'b1;
                    rec  = step_i ? {1'b0, CNT_W'(1)} : '0;
                end else if (step_i) begin
                    state_d = ACCUM;
                    cnt_d   = CNT_W'(1);
                end
            end
            ACCUM: begin
                if (last_i) begin
                    push    = 1'b1;
                    rec     = step_i ? {inc_sat, inc_cnt} : {sat_q, cnt_q};
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end else if (step_i) begin
                    cnt_d = inc_cnt;
                    sat_d = inc_sat;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;

    rlc_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (rec),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    assign sat_o = head[REC_W-1];
    assign len_o = head[CNT_W-1:0];

    // Registered drop pulse when a record meets a full FIFO with no pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= push && full && !pop;
    end
    assign drop_o = drop_q;

`ifdef RLC_STATS_EN
    logic [15:0] runs_q, drops_q;

    // Wrapping counters of accepted and discarded records.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            runs_q  <= '0;
            drops_q <= '0;
        end else begin
            if (push && (!full || pop)) runs_q  <= runs_q + 1'b1;
            if (push && full && !pop)   drops_q <= drops_q + 1'b1;
        end
    end
    assign runs_o  = runs_q;
    assign drops_o = drops_q;
`endif

endmodule
